// File: rtl/gpr_write_scheduler.sv
// ---------------------------------------------------------------------------
// gpr_write_scheduler
//
// Purpose:
//   Shares the single register-file write port between the ALU writeback path
//   (alu_*) and the load / multi-cycle writeback path (mem_*). Mem normally
//   wins a collision, and the losing ALU write is parked in a one-entry buffer.
//   A buffered write that loses MAX_WAIT arbitrations in a row is forced
//   through. A per-register 2-bit pending counter tells decode about
//   read-after-write hazards on both source ports.
//
// Ports:
//   clock, reset           system clock; synchronous active-low reset
//   alu_req/addr/data      ALU write request (held stable until alu_ack)
//   alu_ack                comb: ALU write taken (granted or buffered)
//   mem_req/addr/data      mem write request (held stable until mem_ack)
//   mem_ack                comb: mem write granted this cycle
//   issue_valid/addr       decode issues an instruction writing issue_addr
//   issue_stall            comb: pending counter for issue_addr is saturated
//   rs0_addr, rs1_addr     decode source registers
//   hazard0, hazard1       comb: source register has a pending write
//   write_enable_          registered RF write enable, active low
//   write_address/data     registered RF write address / data
//
// Handshake: a request is a level. It is consumed in the cycle whose comb
// ack is high, and the requester must keep req/addr/data stable until then.
// A grant in cycle N is driven onto the write port during cycle N+1.
// ---------------------------------------------------------------------------
module gpr_write_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_NUM    = 32,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_req,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ack,
    input  logic                  mem_req,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ack,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  issue_stall,
    input  logic [ADDR_WIDTH-1:0] rs0_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic                  hazard0,
    output logic                  hazard1,
    output logic                  write_enable_,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_next;
    logic                  load_buf;
    logic                  mem_wins;

    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;

    logic [1:0]            pend_cnt [REG_NUM];
    logic [REG_NUM-1:0]    inc_vec;
    logic [REG_NUM-1:0]    dec_vec;
    logic                  issue_inc;
    logic                  grant_dec;

    // Mem wins whenever no ALU write is parked, or the parked one has not yet
    // exhausted its patience.
    assign mem_wins = mem_req &&
                      ((state == EMPTY) || (wait_cnt < WAIT_W'(MAX_WAIT)));

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= EMPTY;
            wait_cnt <= '0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (load_buf) begin
                buf_addr <= alu_addr;
                buf_data <= alu_data;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        load_buf   = 1'b0;
        case (state)
            EMPTY: begin
                if (mem_req && alu_req) begin
                    state_next = HELD;
                    wait_next  = '0;
                    load_buf   = 1'b1;
                end
            end
            HELD: begin
                if (mem_wins) begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end else if (alu_req) begin
                    // Buffer drains and refills in the same cycle.
                    load_buf  = 1'b1;
                    wait_next = '0;
                end else begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // ---------------- output / grant logic ----------------
    // The buffer is granted before any newer ALU write, which keeps ALU
    // writes in program order.
    always_comb begin
        alu_ack     = 1'b0;
        mem_ack     = 1'b0;
        grant_valid = 1'b0;
        grant_addr  = '0;
        grant_data  = '0;
        if (mem_wins) begin
            mem_ack     = 1'b1;
            grant_valid = 1'b1;
            grant_addr  = mem_addr;
            grant_data  = mem_data;
            alu_ack     = alu_req && (state == EMPTY);
        end else if (state == HELD) begin
            grant_valid = 1'b1;
            grant_addr  = buf_addr;
            grant_data  = buf_data;
            alu_ack     = alu_req;
        end else if (alu_req) begin
            alu_ack     = 1'b1;
            grant_valid = 1'b1;
            grant_addr  = alu_addr;
            grant_data  = alu_data;
        end
    end

    // ---------------- register file write port ----------------
    // Register 0 grants are consumed but never assert the write enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            write_enable_ <= 1'b1;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            write_enable_ <= !(grant_valid && (grant_addr != '0));
            if (grant_valid) begin
                write_address <= grant_addr;
                write_data    <= grant_data;
            end
        end
    end

    // ---------------- pending-write scoreboard ----------------
    // The counter is decremented in the grant cycle: the RF write-through
    // bypass supplies the value during the commit cycle, so the hazard may
    // drop one cycle before the data is architecturally in the file.
    assign grant_dec   = grant_valid && (grant_addr != '0);
    assign issue_stall = (pend_cnt[issue_addr] == 2'd3) &&
                         !(grant_dec && (grant_addr == issue_addr));
    assign issue_inc   = issue_valid && !issue_stall && (issue_addr != '0);
    assign hazard0     = (pend_cnt[rs0_addr] != 2'd0);
    assign hazard1     = (pend_cnt[rs1_addr] != 2'd0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            inc_vec[i] = issue_inc && (issue_addr == ADDR_WIDTH'(i));
            dec_vec[i] = grant_dec && (grant_addr == ADDR_WIDTH'(i));
        end
    end

    // A decrement at zero is a requester protocol error; the counter simply
    // stays at zero rather than wrapping to a false hazard.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                pend_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    pend_cnt[i] <= pend_cnt[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i] &&
                             (pend_cnt[i] != 2'd0)) begin
                    pend_cnt[i] <= pend_cnt[i] - 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/gpr_write_scheduler.md
Name: gpr_write_scheduler

Overview:
- Shares the single general-purpose register file write port between two writeback sources: the ALU result path (exe) and the load/multi-cycle result path (mem).
- Tracks in-flight destination registers in a per-register scoreboard, so decode can detect read-after-write hazards on both read ports.
- Sits between the execute and memory stages and the register file write port.
- Outputs are registered and drive the register file's write enable, address and data directly.

Parameters:
- DATA_WIDTH, 32, width of a register word.
- ADDR_WIDTH, 5, width of a register address.
- REG_NUM, 32, number of registers.
- MAX_WAIT, 3, number of cycles a buffered ALU write may lose arbitration to mem before it is forced through.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- alu_req  in  1  ALU write request, active high.
- alu_addr  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ack  out  1  combinational; request taken this cycle (granted or buffered).
- mem_req  in  1  mem write request, active high.
- mem_addr  in  ADDR_WIDTH  mem destination register.
- mem_data  in  DATA_WIDTH  mem result.
- mem_ack  out  1  combinational; mem granted this cycle.
- issue_valid  in  1  decode issues an instruction that writes a register.
- issue_addr  in  ADDR_WIDTH  destination of the issued instruction.
- issue_stall  out  1  combinational; scoreboard counter for issue_addr is saturated, so the issue is not recorded.
- rs0_addr, rs1_addr  in  ADDR_WIDTH  decode source registers.
- hazard0, hazard1  out  1  combinational; pending counter of rs0/rs1 is nonzero.
- write_enable_  out  1  registered register file write enable, active low.
- write_address  out  ADDR_WIDTH  registered write address.
- write_data  out  DATA_WIDTH  registered write data.

Behaviour:
- Reset (reset==0 at a clock edge) forces:
  - write_enable_=1, write_address=0, write_data=0.
  - ALU buffer empty, wait counter 0, all scoreboard counters 0.
  - Consequently hazard0/hazard1=0.
- Reset overrides any request in the same cycle. Buffered data is discarded.
- Two states:
  - EMPTY: ALU buffer free.
  - HELD: buffer holds one ALU write (addr, data).
- Arbitration, one commit per cycle, evaluated combinationally:
  - EMPTY, mem_req=1: mem granted (mem_ack=1). If alu_req=1, the ALU write is buffered (alu_ack=1), state goes to HELD, wait counter is set to 0.
  - EMPTY, mem_req=0, alu_req=1: ALU granted directly (alu_ack=1).
  - HELD, wait<MAX_WAIT, mem_req=1: mem granted, wait counter increments, alu_ack=0.
  - HELD, wait==MAX_WAIT, or mem_req=0: buffer granted, mem_ack=0.
  - HELD and the buffer is granted: a new alu_req is accepted into the buffer the same cycle (alu_ack=1), wait counter resets to 0, state stays HELD. Otherwise state goes to EMPTY.
  - The buffer always commits before any newer ALU write, which preserves ALU ordering.
- Commit latency: a grant in cycle N produces write_enable_=0 with the granted addr/data during cycle N+1. With no grant, write_enable_=1 and addr/data hold their previous values.
- Register 0 grants:
  - Accepted and acked like any other grant.
  - write_enable_ stays 1 for that commit.
  - The scoreboard is not touched, and register 0 is never marked pending.
- Scoreboard:
  - A 2-bit counter per register.
  - Increments on issue_valid && !issue_stall && issue_addr!=0.
  - Decrements on a grant to that address, in the grant cycle, so hazard clears in cycle N+1, when the register file write-through bypass supplies the data.
  - Simultaneous increment and decrement on the same register leaves the counter unchanged.
  - issue_stall=1 when the counter is 3 and no same-cycle grant to that address exists.
  - A decrement at 0 is a protocol error: the counter stays at 0.
- Requesters hold their req/addr/data stable until acked.

Test Plan:
- ALU only: alu_req=1, addr=5, data=0x11 in cycle 0 -> alu_ack=1 in cycle 0; write_enable_=0, address 5, data 0x11 in cycle 1.
- Collision: alu (3, 0xA) and mem (4, 0xB) in the same cycle -> mem commits in cycle 1, buffered ALU write commits in cycle 2, alu_ack=1 in cycle 0.
- Starvation: buffer HELD with (7, 0xC) and mem_req held high with MAX_WAIT=3 -> three mem commits, then 0xC to register 7 on the 4th commit, with mem_ack=0 in that grant cycle.
- Scoreboard:
  - issue_addr=9 -> hazard0=1 with rs0_addr=9 from the next cycle.
  - A grant to 9 -> hazard0=0 the following cycle.
  - Issuing 9 four times without writes -> 4th issue gives issue_stall=1.
- Register 0: alu_req with addr 0 -> alu_ack=1, write_enable_ stays 1, hazard never set for rs0_addr=0.
- Reset mid-operation: reset=0 while HELD with pending counters -> next cycle write_enable_=1, buffer empty, all hazards 0, and a subsequent alu_req is granted directly.
